// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult
// Description : Sequential shift-and-add multiplier that takes WIDTH RUN
//               cycles and produces a 2*WIDTH-bit product. Define the
//               MULT_SIGNED_EN macro to add two's-complement operand support
//               through the signed_mode input.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
`ifdef MULT_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int             c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CW-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_done;

    logic                 w_last;
    logic                 w_subtract;
    logic [2*WIDTH-1:0]   w_mcand_ext;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_last   = (r_count == c_LAST);
    assign w_addend = r_mplier[0] ? r_mcand : '0;

`ifdef MULT_SIGNED_EN
    logic r_signed;

    assign w_mcand_ext = signed_mode ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                                     : {{WIDTH{1'b0}}, multiplicand};
    // The multiplier MSB carries negative weight in two's complement.
    assign w_subtract  = r_signed && w_last;
`else
    assign w_mcand_ext = {{WIDTH{1'b0}}, multiplicand};
    assign w_subtract  = 1'b0;
`endif

    assign w_acc_next = w_subtract ? (r_acc - w_addend) : (r_acc + w_addend);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
`ifdef MULT_SIGNED_EN
            r_signed  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_mcand_ext;
                        r_mplier <= multiplier;
                        r_acc    <= '0;
                        r_count  <= '0;
`ifdef MULT_SIGNED_EN
                        r_signed <= signed_mode;
`endif
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + c_CW'(1);
                end
                S_DONE: begin
                    r_product <= r_acc;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult
// Description : Scoreboard bench for shift_add_mult at WIDTH 8, 16 and 32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic        start8 = 1'b0, start16 = 1'b0, start32 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        sm8 = 1'b0;
    logic        busy8, busy16, busy32;
    logic        done8, done16, done32;
    logic [15:0] product8;
    logic [31:0] product16;
    logic [63:0] product32;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q32[$];

    logic track16 = 1'b0;
    int   low16 = 0;
    int   max_low16 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_add_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .multiplicand(a8), .multiplier(b8),
`ifdef MULT_SIGNED_EN
        .signed_mode(sm8),
`endif
        .busy(busy8), .done(done8), .product(product8)
    );

    shift_add_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16),
        .multiplicand(a16), .multiplier(b16),
`ifdef MULT_SIGNED_EN
        .signed_mode(1'b0),
`endif
        .busy(busy16), .done(done16), .product(product16)
    );

    shift_add_mult #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32),
        .multiplicand(a32), .multiplier(b32),
`ifdef MULT_SIGNED_EN
        .signed_mode(1'b0),
`endif
        .busy(busy32), .done(done32), .product(product32)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitors: pop an expectation whenever a done pulse appears.
    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut8 unexpected done: got product %h expected no done", product8);
            end else begin
                e = q8.pop_front();
                check("dut8 product", {48'b0, product8}, e.prod);
                check("dut8 done cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut16 unexpected done: got product %h expected no done", product16);
            end else begin
                e = q16.pop_front();
                check("dut16 product", {32'b0, product16}, e.prod);
                check("dut16 done cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut32 unexpected done: got product %h expected no done", product32);
            end else begin
                e = q32.pop_front();
                check("dut32 product", product32, e.prod);
                check("dut32 done cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        if (track16) begin
            if (!busy16) begin
                low16++;
                if (low16 > max_low16) max_low16 = low16;
            end else begin
                low16 = 0;
            end
        end
    end

    task automatic wait_empty(input int which, input int limit);
        int k = 0;
        int n;
        n = (which == 8) ? q8.size() : (which == 16) ? q16.size() : q32.size();
        while (n != 0 && k < limit) begin
            @(negedge clk);
            k++;
            n = (which == 8) ? q8.size() : (which == 16) ? q16.size() : q32.size();
        end
        if (n != 0) begin
            tests++; fails++;
            $display("FAIL dut%0d timeout: got %0d pending results expected 0", which, n);
            q8.delete(); q16.delete(); q32.delete();
        end
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] exp);
        int k = 0;
        @(negedge clk);
        while (busy8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        q8.push_back('{prod: {48'b0, exp}, due: cyc + 10});
        @(negedge clk);
        start8 = 1'b0;
        wait_empty(8, 40);
    endtask

    initial begin
        int s;
        repeat (3) @(negedge clk);
        check("reset busy8", {63'b0, busy8}, 64'd0);
        check("reset done8", {63'b0, done8}, 64'd0);
        check("reset product8", {48'b0, product8}, 64'd0);
        check("reset busy16", {63'b0, busy16}, 64'd0);
        check("reset product16", {32'b0, product16}, 64'd0);
        check("reset busy32", {63'b0, busy32}, 64'd0);
        check("reset product32", product32, 64'd0);
        rst = 1'b0;

        // WIDTH=32 all-ones operands, done 33 edges after the start edge
        @(negedge clk);
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; start32 = 1'b1;
        q32.push_back('{prod: 64'hFFFF_FFFE_0000_0001, due: cyc + 34});
        @(negedge clk);
        start32 = 1'b0;
        wait_empty(32, 60);

        mul8(8'h00, 8'hAB, 1'b0, 16'h0000);
        mul8(8'd13, 8'd11, 1'b0, 16'h008F);
        mul8(8'h80, 8'h80, 1'b0, 16'h4000);
        mul8(8'hFD, 8'h05, 1'b0, 16'h04F1);
`ifdef MULT_SIGNED_EN
        mul8(8'hFD, 8'h05, 1'b1, 16'hFFF1);
        mul8(8'h80, 8'h80, 1'b1, 16'h4000);
        mul8(8'h7F, 8'h81, 1'b1, 16'hC0FF);
`endif
        mul8(8'hFF, 8'hFF, 1'b0, 16'hFE01);

        // WIDTH=16 back-to-back with start held high, operands changed after each accept
        @(negedge clk);
        s = cyc;
        a16 = 16'h0003; b16 = 16'h0005; start16 = 1'b1;
        q16.push_back('{prod: 64'h0000_000F, due: s + 18});
        q16.push_back('{prod: 64'h0000_FF00, due: s + 36});
        q16.push_back('{prod: 64'h0001_FFFE, due: s + 54});
        @(negedge clk);
        track16 = 1'b1;
        a16 = 16'h00FF; b16 = 16'h0100;
        repeat (18) @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0002;
        repeat (18) @(negedge clk);
        start16 = 1'b0;
        track16 = 1'b0;
        wait_empty(16, 40);
        check("dut16 max busy-low run", 64'(max_low16), 64'd1);

        // Start re-pulsed in RUN cycle 3 must be ignored
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; start8 = 1'b1;
        q8.push_back('{prod: 64'h03A8, due: cyc + 10});
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'h55; b8 = 8'h66; start8 = 1'b1;
        check("dut8 product hold in RUN", {48'b0, product8}, 64'hFE01);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h77; b8 = 8'h99;
        wait_empty(8, 40);
        repeat (12) @(negedge clk);

        // Asynchronous reset at RUN cycle 4 aborts without a done pulse
        a8 = 8'h0F; b8 = 8'h0F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy8", {63'b0, busy8}, 64'd0);
        check("abort done8", {63'b0, done8}, 64'd0);
        check("abort product8", {48'b0, product8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mul8(8'd2, 8'd3, 1'b0, 16'h0006);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
